// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
// Handshake: imem_req is a level held (with imem_addr stable) until imem_done; imem_done may arrive in the first req cycle.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_done, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_done, output imem_data);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues imem fetches, holds a one-entry skid buffer and the IF/ID register,
// and applies redirects (siic > rti > redir_valid), drains squashed accesses and stops on halt.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redir_valid,
  input  logic [15:0]              redir_pc,
  input  logic                     siic,
  input  logic [15:0]              siic_epc,
  input  logic                     rti,
  input  logic                     halt,
  fetch_sequencer_if.master        imem,
  output logic                     fetch_valid,
  output logic [15:0]              instr,
  output logic [15:0]              instr_pc,
  output logic [15:0]              instr_pc_inc,
  output logic                     flush,
  output logic [15:0]              epc,
  output logic                     halted,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;
  logic        halt_pend_q, halt_pend_d;
  logic [15:0] epc_q, epc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] buf_data_q, buf_data_d;
  logic [15:0] buf_pc_q, buf_pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;

  logic        req;
  logic        redirect;
  logic [15:0] target;
  logic        in_flight;
  logic        complete;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    busy_d        = busy_q;
    halt_pend_d   = halt_pend_q;
    epc_d         = epc_q;
    buf_valid_d   = buf_valid_q;
    buf_data_d    = buf_data_q;
    buf_pc_d      = buf_pc_q;
    fetch_valid_d = fetch_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    req           = 1'b0;
    redirect      = 1'b0;
    target        = pc_q;

    case (state_q)
      ST_FETCH: req = busy_q | (~buf_valid_q & ~halt_pend_q);
      ST_DRAIN: req = 1'b1;
      default:  req = 1'b0;
    endcase

    // Redirects are ignored once halted; only reset leaves HALT.
    if (state_q != ST_HALT) begin
      if (siic) begin
        redirect = 1'b1;
        target   = EXC_VECTOR;
        epc_d    = siic_epc;
      end else if (rti) begin
        redirect = 1'b1;
        target   = epc_q;
      end else if (redir_valid) begin
        redirect = 1'b1;
        target   = redir_pc;
      end
    end

    // A request presented without done counts as outstanding, even in its first cycle.
    in_flight = req & ~imem.imem_done;
    complete  = ~drop_q & req & imem.imem_done & ~redirect;
    busy_d    = in_flight;

    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          pc_d        = target;
          halt_pend_d = 1'b0;
          if (in_flight) state_d = ST_DRAIN;
        end else begin
          if (complete) begin
            pc_d = pc_q + 16'd2;
            if (halt_pend_q) begin
              state_d     = ST_HALT;
              halt_pend_d = 1'b0;
            end
          end
          if (halt) begin
            if (in_flight) halt_pend_d = 1'b1;
            else           state_d     = ST_HALT;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          pc_d        = target;
          halt_pend_d = 1'b0;
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end
        if (imem.imem_done) begin
          state_d     = halt_pend_d ? ST_HALT : ST_FETCH;
          halt_pend_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (redirect) begin
      fetch_valid_d = 1'b0;
      buf_valid_d   = 1'b0;
    end else if (state_q != ST_HALT) begin
      if (stall) begin
        if (complete) begin
          buf_valid_d = 1'b1;
          buf_data_d  = imem.imem_data;
          buf_pc_d    = addr_q;
        end
      end else if (buf_valid_q) begin
        fetch_valid_d = 1'b1;
        instr_d       = buf_data_q;
        instr_pc_d    = buf_pc_q;
        buf_valid_d   = 1'b0;
      end else if (complete) begin
        fetch_valid_d = 1'b1;
        instr_d       = imem.imem_data;
        instr_pc_d    = addr_q;
      end else begin
        fetch_valid_d = 1'b0;
      end
    end

    drop_d = (state_d == ST_DRAIN);
    // Fetch address tracks the next PC whenever no access is outstanding, so a new access starts at pc.
    addr_d = in_flight ? addr_q : pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      busy_q        <= 1'b0;
      drop_q        <= 1'b0;
      halt_pend_q   <= 1'b0;
      epc_q         <= 16'h0000;
      buf_valid_q   <= 1'b0;
      buf_data_q    <= 16'h0000;
      buf_pc_q      <= 16'h0000;
      fetch_valid_q <= 1'b0;
      instr_q       <= 16'h0000;
      instr_pc_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      drop_q        <= drop_d;
      halt_pend_q   <= halt_pend_d;
      epc_q         <= epc_d;
      buf_valid_q   <= buf_valid_d;
      buf_data_q    <= buf_data_d;
      buf_pc_q      <= buf_pc_d;
      fetch_valid_q <= fetch_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr_q;
  assign fetch_valid    = fetch_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_pc_inc   = instr_pc_q + 16'd2;
  assign flush          = redirect;
  assign epc            = epc_q;
  assign halted         = (state_q == ST_HALT);
  assign dbg_state      = state_q;

endmodule
